// File: rtl/rs_simple_if.sv
// Signal bundle between the simple-ALU reservation station and its dispatch/CDB/execute neighbours.
// The slave modport is the reservation station itself.
interface rs_simple_if #(
    parameter int unsigned CNT_W = 3
);
    logic             flush;
    logic             dispatch_valid;
    logic [76:0]      dispatch_entry;
    logic             rs_full;
    logic             cdb_valid;
    logic [4:0]       cdb_tag;
    logic [31:0]      cdb_data;
    logic [76:0]      rs_simple_0;
    logic [76:0]      rs_simple_1;
    logic             selector;
    logic             simple_0_issue;
    logic             simple_1_issue;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, dispatch_valid, dispatch_entry, cdb_valid, cdb_tag, cdb_data,
               simple_0_issue, simple_1_issue,
        input  rs_full, rs_simple_0, rs_simple_1, selector, count
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_entry, cdb_valid, cdb_tag, cdb_data,
               simple_0_issue, simple_1_issue,
        output rs_full, rs_simple_0, rs_simple_1, selector, count
    );
endinterface

// File: rtl/rs_simple.sv
// Age-ordered reservation station for the simple ALU with CDB wakeup and compaction on issue.
// Optional macro RS_CDB_BYPASS_EN: dispatched entries also capture a same-cycle CDB broadcast.
module rs_simple #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input logic         clk,
    input logic         rst_n,
    rs_simple_if.slave  bus
);
    localparam int unsigned EW = 77;

    logic [EW-1:0]    r_entry [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic             r_sel;

    // One extra all-zero slot so the shift-down source for the top entry is uniform.
    logic [EW-1:0]    w_woken [DEPTH+1];
    logic [EW-1:0]    w_next  [DEPTH];
    logic [EW-1:0]    w_disp;
    logic             w_full;
    logic             w_accept;
    logic             w_rm0;
    logic             w_rm1;
    logic             w_removed;
    logic [CNT_W-1:0] w_wr_idx;
    logic [CNT_W-1:0] w_count_next;

    function automatic logic [EW-1:0] cdb_wake(input logic [EW-1:0] e, input logic v,
                                               input logic [4:0] tag, input logic [31:0] data);
        logic [EW-1:0] r;
        r = e;
        if (v && !e[10] && (e[15:11] == tag)) begin
            r[10]    = 1'b1;
            r[42:11] = data;
        end
        if (v && !e[43] && (e[48:44] == tag)) begin
            r[43]    = 1'b1;
            r[75:44] = data;
        end
        return r;
    endfunction

    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_accept     = bus.dispatch_valid && !w_full;
    assign w_rm0        = bus.simple_0_issue && (r_count != '0);
    assign w_rm1        = bus.simple_1_issue && !bus.simple_0_issue && (r_count > CNT_W'(1));
    assign w_removed    = w_rm0 | w_rm1;
    assign w_wr_idx     = r_count - CNT_W'(w_removed);
    assign w_count_next = r_count + CNT_W'(w_accept) - CNT_W'(w_removed);

`ifdef RS_CDB_BYPASS_EN
    assign w_disp = cdb_wake(bus.dispatch_entry, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
`else
    assign w_disp = bus.dispatch_entry;
`endif

    // Only occupied slots wake; empty slots are zero and would otherwise match tag 0.
    always_comb begin
        for (int unsigned i = 0; i <= DEPTH; i++) begin
            w_woken[i] = '0;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < r_count) begin
                w_woken[i] = cdb_wake(r_entry[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_next[i] = w_woken[i];
            if (w_removed && (CNT_W'(i) >= CNT_W'(w_rm1))) begin
                w_next[i] = w_woken[i+1];
            end
            if (w_accept && (CNT_W'(i) == w_wr_idx)) begin
                w_next[i] = w_disp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_count <= '0;
            r_sel   <= 1'b1;
        end else if (bus.flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_count <= '0;
            r_sel   <= 1'b1;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entry[i] <= w_next[i];
            end
            r_count <= w_count_next;
            if (w_removed && (w_count_next >= CNT_W'(2))) begin
                r_sel <= ~r_sel;
            end
        end
    end

    assign bus.rs_full     = w_full;
    assign bus.count       = r_count;
    assign bus.selector    = r_sel;
    assign bus.rs_simple_0 = r_entry[0];
    assign bus.rs_simple_1 = r_entry[1];
endmodule

// File: tb/tb_rs_simple.sv
// Bench for rs_simple: directed scenarios plus random traffic against a queue-based model.
module tb_rs_simple;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rs_simple_if #(.CNT_W(CNT_W)) bus ();

    rs_simple #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    logic [76:0]   mq[$];
    logic          m_sel = 1'b1;
    logic [76:0]   ents[5];

    function automatic logic [76:0] mk(input logic rf, input logic [31:0] v2, input logic r2,
                                       input logic [31:0] v1, input logic r1,
                                       input logic [4:0] rd, input logic [4:0] op);
        return {rf, v2, r2, v1, r1, rd, op};
    endfunction

    // Each operand: ready bit just below a 32-bit value field whose low 5 bits are the tag.
    function automatic logic [76:0] ref_wake(input logic [76:0] e, input logic v,
                                             input logic [4:0] tag, input logic [31:0] data);
        int lo;
        for (int k = 0; k < 2; k++) begin
            lo = (k == 0) ? 11 : 44;
            if (v && !e[lo-1] && (e[lo+:5] == tag)) begin
                e[lo-1]  = 1'b1;
                e[lo+:32] = data;
            end
        end
        return e;
    endfunction

    function automatic logic [76:0] exp_slot(input int idx);
        return (mq.size() > idx) ? mq[idx] : 77'd0;
    endfunction

    task automatic idle();
        bus.flush          = 1'b0;
        bus.dispatch_valid = 1'b0;
        bus.dispatch_entry = '0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_tag        = '0;
        bus.cdb_data       = '0;
        bus.simple_0_issue = 1'b0;
        bus.simple_1_issue = 1'b0;
    endtask

    task automatic model_edge();
        logic [76:0] e;
        bit acc;
        bit rem;
        if (bus.flush) begin
            mq.delete();
            m_sel = 1'b1;
            return;
        end
        acc = bus.dispatch_valid && (mq.size() < DEPTH);
        foreach (mq[i]) mq[i] = ref_wake(mq[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        rem = 1'b0;
        if (bus.simple_0_issue && mq.size() > 0) begin
            mq.delete(0);
            rem = 1'b1;
        end else if (bus.simple_1_issue && mq.size() > 1) begin
            mq.delete(1);
            rem = 1'b1;
        end
        if (acc) begin
            e = bus.dispatch_entry;
`ifdef RS_CDB_BYPASS_EN
            e = ref_wake(e, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
`endif
            mq.push_back(e);
        end
        if (rem && mq.size() >= 2) m_sel = ~m_sel;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            bus.dispatch_valid = 1'b1;
            bus.dispatch_entry = ents[i];
            step();
        end
        idle();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1 && mq.size() > 0; i++) begin
            idle();
            bus.simple_0_issue = 1'b1;
            step();
        end
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.rs_simple_0 !== 77'd0) $display("FAIL reset_slot0 got %h want 0", bus.rs_simple_0);
        else n_pass++;
        n_checks++;
        if (bus.rs_simple_1 !== 77'd0) $display("FAIL reset_slot1 got %h want 0", bus.rs_simple_1);
        else n_pass++;
        n_checks++;
        if (bus.count !== 3'd0) $display("FAIL reset_count got %0d want 0", bus.count);
        else n_pass++;
        n_checks++;
        if (bus.rs_full !== 1'b0) $display("FAIL reset_full got %b want 0", bus.rs_full);
        else n_pass++;
        n_checks++;
        if (bus.selector !== 1'b1) $display("FAIL reset_selector got %b want 1", bus.selector);
        else n_pass++;
        mq.delete();
        m_sel = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [76:0] a;
        a = mk(1'b1, 32'd5, 1'b1, 32'd3, 1'b1, 5'd7, 5'd0);
        idle();
        bus.dispatch_valid = 1'b1;
        bus.dispatch_entry = a;
        step();
        n_checks++;
        if (bus.rs_simple_0 !== a) $display("FAIL basic_slot0 got %h want %h", bus.rs_simple_0, a);
        else n_pass++;
        n_checks++;
        if (bus.count !== 3'd1) $display("FAIL basic_count got %0d want 1", bus.count);
        else n_pass++;
        n_checks++;
        if (bus.rs_simple_1 !== 77'd0) $display("FAIL basic_slot1 got %h want 0", bus.rs_simple_1);
        else n_pass++;
        drain();
        n_checks++;
        if (bus.count !== 3'd0) $display("FAIL basic_drain_count got %0d want 0", bus.count);
        else n_pass++;
    endtask

    task automatic test_wakeup();
        logic [76:0] w;
        logic [76:0] w_exp;
        w     = mk(1'b0, 32'h11, 1'b1, 32'd9, 1'b0, 5'd2, 5'd1);
        w_exp = mk(1'b0, 32'h11, 1'b1, 32'hDEADBEEF, 1'b1, 5'd2, 5'd1);
        idle();
        bus.dispatch_valid = 1'b1;
        bus.dispatch_entry = w;
        step();
        idle();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 5'd8;
        bus.cdb_data  = 32'h12345678;
        step();
        n_checks++;
        if (bus.rs_simple_0 !== w) $display("FAIL wake_wrong_tag got %h want %h", bus.rs_simple_0, w);
        else n_pass++;
        bus.cdb_tag  = 5'd9;
        bus.cdb_data = 32'hDEADBEEF;
        step();
        n_checks++;
        if (bus.rs_simple_0[10] !== 1'b1) $display("FAIL wake_ready got %b want 1", bus.rs_simple_0[10]);
        else n_pass++;
        n_checks++;
        if (bus.rs_simple_0 !== w_exp)
            $display("FAIL wake_entry got %h want %h", bus.rs_simple_0, w_exp);
        else n_pass++;
        drain();
    endtask

    task automatic test_compaction();
        fill(4);
        n_checks++;
        if (bus.rs_full !== 1'b1) $display("FAIL comp_full got %b want 1", bus.rs_full);
        else n_pass++;
        bus.simple_1_issue = 1'b1;
        step();
        idle();
        n_checks++;
        if (bus.rs_simple_0 !== ents[0] || bus.rs_simple_1 !== ents[2])
            $display("FAIL comp_slots got %h %h want %h %h", bus.rs_simple_0, bus.rs_simple_1,
                     ents[0], ents[2]);
        else n_pass++;
        n_checks++;
        if (bus.count !== 3'd3 || bus.rs_full !== 1'b0)
            $display("FAIL comp_count got %0d/%b want 3/0", bus.count, bus.rs_full);
        else n_pass++;
        n_checks++;
        if (bus.selector !== m_sel) $display("FAIL comp_selector got %b want %b", bus.selector, m_sel);
        else n_pass++;
        bus.simple_0_issue = 1'b1;
        step();
        idle();
        n_checks++;
        if (bus.rs_simple_0 !== ents[2] || bus.rs_simple_1 !== ents[3])
            $display("FAIL comp_tail got %h %h want %h %h", bus.rs_simple_0, bus.rs_simple_1,
                     ents[2], ents[3]);
        else n_pass++;
        drain();
    endtask

    task automatic test_full_boundary();
        fill(4);
        bus.dispatch_valid = 1'b1;
        bus.dispatch_entry = ents[4];
        bus.simple_0_issue = 1'b1;
        step();
        n_checks++;
        if (bus.count !== 3'd3) $display("FAIL full_refuse_count got %0d want 3", bus.count);
        else n_pass++;
        n_checks++;
        if (bus.rs_simple_0 !== ents[1] || bus.rs_simple_1 !== ents[2])
            $display("FAIL full_refuse_slots got %h %h want %h %h", bus.rs_simple_0,
                     bus.rs_simple_1, ents[1], ents[2]);
        else n_pass++;
        bus.simple_0_issue = 1'b0;
        step();
        idle();
        n_checks++;
        if (bus.count !== 3'd4 || bus.rs_full !== 1'b1)
            $display("FAIL full_accept got %0d/%b want 4/1", bus.count, bus.rs_full);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            bus.simple_0_issue = 1'b1;
            step();
        end
        idle();
        n_checks++;
        if (bus.rs_simple_0 !== ents[4])
            $display("FAIL full_slot3 got %h want %h", bus.rs_simple_0, ents[4]);
        else n_pass++;
        drain();
    endtask

    task automatic test_simultaneous();
        logic [76:0] e;
        logic [76:0] e_exp;
        e = mk(1'b1, 32'h55, 1'b1, 32'd19, 1'b0, 5'd4, 5'd2);
`ifdef RS_CDB_BYPASS_EN
        e_exp = mk(1'b1, 32'h55, 1'b1, 32'hCAFEF00D, 1'b1, 5'd4, 5'd2);
`else
        e_exp = e;
`endif
        fill(2);
        bus.dispatch_valid = 1'b1;
        bus.dispatch_entry = e;
        bus.simple_0_issue = 1'b1;
        bus.cdb_valid      = 1'b1;
        bus.cdb_tag        = 5'd19;
        bus.cdb_data       = 32'hCAFEF00D;
        step();
        idle();
        n_checks++;
        if (bus.count !== 3'd2) $display("FAIL simul_count got %0d want 2", bus.count);
        else n_pass++;
        n_checks++;
        if (bus.rs_simple_0 !== ents[1]) $display("FAIL simul_slot0 got %h want %h",
                                                  bus.rs_simple_0, ents[1]);
        else n_pass++;
        n_checks++;
        if (bus.rs_simple_1 !== e_exp) $display("FAIL simul_slot1 got %h want %h",
                                                bus.rs_simple_1, e_exp);
        else n_pass++;
        drain();
    endtask

    task automatic test_flush();
        fill(3);
        bus.flush          = 1'b1;
        bus.dispatch_valid = 1'b1;
        bus.dispatch_entry = ents[3];
        bus.simple_1_issue = 1'b1;
        step();
        idle();
        n_checks++;
        if (bus.count !== 3'd0 || bus.rs_full !== 1'b0)
            $display("FAIL flush_count got %0d/%b want 0/0", bus.count, bus.rs_full);
        else n_pass++;
        n_checks++;
        if (bus.rs_simple_0 !== 77'd0 || bus.rs_simple_1 !== 77'd0)
            $display("FAIL flush_slots got %h %h want 0 0", bus.rs_simple_0, bus.rs_simple_1);
        else n_pass++;
        n_checks++;
        if (bus.selector !== 1'b1) $display("FAIL flush_selector got %b want 1", bus.selector);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] v1;
        logic [31:0] v2;
        logic        r1;
        logic        r2;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r1 = 1'($urandom_range(0, 1));
            r2 = 1'($urandom_range(0, 1));
            v1 = $urandom();
            v2 = $urandom();
            if (!r1) v1[4:0] = 5'($urandom_range(0, 7));
            if (!r2) v2[4:0] = 5'($urandom_range(0, 7));
            bus.flush          = ($urandom_range(0, 31) == 0);
            bus.dispatch_valid = 1'($urandom_range(0, 1));
            bus.dispatch_entry = mk(1'($urandom_range(0, 1)), v2, r2, v1, r1,
                                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            bus.cdb_valid      = 1'($urandom_range(0, 1));
            bus.cdb_tag        = 5'($urandom_range(0, 7));
            bus.cdb_data       = $urandom();
            bus.simple_0_issue = ($urandom_range(0, 3) == 0);
            bus.simple_1_issue = ($urandom_range(0, 3) == 0);
            step();
            n_checks++;
            if (bus.count !== CNT_W'(mq.size()) || bus.rs_full !== (mq.size() == DEPTH) ||
                bus.selector !== m_sel)
                $display("FAIL rand_state cyc %0d got cnt=%0d full=%b sel=%b want %0d/%b/%b",
                         cyc, bus.count, bus.rs_full, bus.selector, mq.size(),
                         (mq.size() == DEPTH), m_sel);
            else n_pass++;
            n_checks++;
            if (bus.rs_simple_0 !== exp_slot(0) || bus.rs_simple_1 !== exp_slot(1))
                $display("FAIL rand_slots cyc %0d got %h %h want %h %h", cyc, bus.rs_simple_0,
                         bus.rs_simple_1, exp_slot(0), exp_slot(1));
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_async_reset();
        drain();
        fill(3);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.rs_simple_0 !== 77'd0 || bus.rs_simple_1 !== 77'd0)
            $display("FAIL areset_slots got %h %h want 0 0", bus.rs_simple_0, bus.rs_simple_1);
        else n_pass++;
        n_checks++;
        if (bus.count !== 3'd0 || bus.selector !== 1'b1)
            $display("FAIL areset_state got cnt=%0d sel=%b want 0/1", bus.count, bus.selector);
        else n_pass++;
        mq.delete();
        m_sel = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.dispatch_valid = 1'b1;
        bus.dispatch_entry = ents[0];
        step();
        idle();
        n_checks++;
        if (bus.count !== 3'd1 || bus.rs_simple_0 !== ents[0])
            $display("FAIL areset_resume got cnt=%0d %h want 1 %h", bus.count, bus.rs_simple_0,
                     ents[0]);
        else n_pass++;
    endtask

    initial begin
        ents[0] = mk(1'b1, 32'hA2A2A2A2, 1'b1, 32'hA1A1A1A1, 1'b1, 5'd1, 5'd3);
        ents[1] = mk(1'b0, 32'hB2B2B2B2, 1'b1, 32'hB1B1B1B1, 1'b1, 5'd2, 5'd4);
        ents[2] = mk(1'b1, 32'hC2C2C2C2, 1'b1, 32'hC1C1C1C1, 1'b1, 5'd3, 5'd5);
        ents[3] = mk(1'b1, 32'hD2D2D2D2, 1'b1, 32'hD1D1D1D1, 1'b1, 5'd4, 5'd6);
        ents[4] = mk(1'b0, 32'hE2E2E2E2, 1'b1, 32'hE1E1E1E1, 1'b1, 5'd5, 5'd7);
        idle();
        test_reset();
        test_basic();
        test_wakeup();
        test_compaction();
        test_full_boundary();
        test_simultaneous();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
